pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Downstream supervisor for the PLL. Synchronises the PLL's asynchronous `locked` flag into the `refclk` domain, qualifies it for a programmable stable period, then sequences an active-low system reset release and a `ready` indication for logic clocked by `outclk_0`/`outclk_1`. Loss of lock at any time re-asserts system reset, and each loss from an operating state increments a saturating counter for debug.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser (minimum 2).
- `LOCK_STABLE_CYCLES`, 16: consecutive synchronised-high cycles required before reset release (minimum 1).
- `RST_HOLD_CYCLES`, 8: cycles between `sys_rst_n` deassertion and `ready` assertion (minimum 1).
- `LOSS_CNT_W`, 8: width of the lock-loss counter.

Ports:
- `refclk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `locked`  in  1  PLL lock flag, asynchronous to `refclk`.
- `sys_rst_n`  out  1  registered active-low reset for downstream logic.
- `ready`  out  1  registered; high only in RUN.
- `lock_loss_cnt`  out  `LOSS_CNT_W`  saturating count of lock losses from RELEASE or RUN.
- `state`  out  2  current FSM state, for debug.

## Operation
- Synchroniser: `SYNC_STAGES` flops; its last stage is `locked_s`. Only `locked_s` drives any other logic.
- FSM states: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3.
  - WAIT_LOCK: `sys_rst_n`=0, `ready`=0, stable counter=0. If `locked_s`=1, go to STABLE.
  - STABLE: stable counter increments each cycle. If `locked_s`=0, go to WAIT_LOCK; the loss counter is not incremented. When the counter reaches `LOCK_STABLE_CYCLES`-1 with `locked_s`=1, go to RELEASE.
  - RELEASE: `sys_rst_n`=1, `ready`=0, and the hold counter runs. If `locked_s`=0, go to WAIT_LOCK and increment the loss counter. After `RST_HOLD_CYCLES` cycles, go to RUN.
  - RUN: `sys_rst_n`=1, `ready`=1. If `locked_s`=0, go to WAIT_LOCK and increment the loss counter.
- Outputs are registered and decoded from the next state, so each changes on the same edge as the state transition.
- Loss counter: increments by 1 per qualifying loss and saturates at all-ones (no wrap). It is cleared only by `rst`.
- The stable and hold counters are `$clog2(max)+1` bits wide. They are cleared on every entry to their state.

## Timing
- Reset (`rst`=0, asynchronous): all synchroniser flops 0, state WAIT_LOCK, `sys_rst_n`=0, `ready`=0, `lock_loss_cnt`=0, `state`=0.
- Reset deassertion is sampled on the next `refclk` edge; there is no combinational path from `rst` to any output other than the asynchronous clear.
- Edges are numbered from edge 1, the first edge that samples `locked`=1.
  - Acquire, with `locked` held high: `sys_rst_n` rises at edge `SYNC_STAGES`+1+`LOCK_STABLE_CYCLES`. `ready` rises `RST_HOLD_CYCLES` edges later. With defaults: `sys_rst_n` at edge 19, `ready` at edge 27.
  - Loss: `sys_rst_n`, `ready` and `state` change, and `lock_loss_cnt` increments, at edge `SYNC_STAGES`+1 after the first edge that samples `locked`=0. With defaults this is 3 edges.
- Glitches on `locked` shorter than one `refclk` period may be missed; this is acceptable.
- A single-cycle low on `locked_s` during STABLE restarts qualification from zero.
- Reset asserted mid-sequence in any state returns immediately to the reset values. The loss counter is cleared, and no loss is counted for the reset itself.

## Structure
- Package `pll_mon_pkg`: `typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} mon_state_t;` and the default parameter constants.
- Sub-module `sync_bit`: a parameterised N-flop synchroniser with asynchronous active-low clear. It is instantiated once for `locked`.
- Top level: FSM, the two phase counters, and the loss counter.

## Test plan
- Power-on: hold `rst`=0 for 3 cycles with `locked`=1. Required: all outputs at reset values. Release `rst`. Required: `sys_rst_n` rises 19 edges after the first edge that samples `locked`=1, and `ready` rises 27 edges after it.
- Chatter: toggle `locked` 1/0 every 5 cycles for 100 cycles. Required: `sys_rst_n` stays 0 and `lock_loss_cnt` stays 0.
- Loss in RUN: reach RUN, then drop `locked` for 20 cycles. Required: `ready`=0, `sys_rst_n`=0 and `state`=0 three edges later; `lock_loss_cnt`=1. Restore `locked`. Required: the full reacquire sequence runs again, with `ready` rising 27 edges after restore.
- Loss in RELEASE: drop `locked` 4 cycles after `sys_rst_n` rises. Required: `ready` never rises, `lock_loss_cnt` increments, and the state returns to WAIT_LOCK.
- Saturation: with `LOSS_CNT_W`=2, force 5 losses from RUN. Required: the count reads 1, 2, 3, 3, 3.
- Async reset mid-RELEASE: assert `rst` between edges. Required: outputs clear immediately, without waiting for an edge, and `lock_loss_cnt`=0.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types and default parameters for the PLL lock supervisor.
// The state encoding is visible on the debug port, so its values are fixed.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } mon_state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 16;
    localparam int DEF_RST_HOLD_CYCLES    = 8;
    localparam int DEF_LOSS_CNT_W         = 8;

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchroniser with asynchronous active-low clear.
// Latency N cycles; no backpressure.
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[N-2:0], d_i};
        end
    end

    assign q_o = ff_q[N-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the PLL lock flag, then sequences downstream reset release and ready.
// Outputs are registered from the next state; no backpressure.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            state
);

    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int HLD_W = $clog2(RST_HOLD_CYCLES) + 1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RST_HOLD_CYCLES - 1);

    logic                  locked_s;
    mon_state_t            state_q, state_d;
    logic [STB_W-1:0]      stb_cnt_q, stb_cnt_d;
    logic [HLD_W-1:0]      hld_cnt_q, hld_cnt_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  ready_q, ready_d;
    logic                  loss_evt;

    sync_bit #(.N(SYNC_STAGES)) u_lock_sync (
        .clk_i   (refclk),
        .rst_n_i (rst),
        .d_i     (locked),
        .q_o     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_LOCK;
            stb_cnt_q   <= '0;
            hld_cnt_q   <= '0;
            loss_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_cnt_q   <= stb_cnt_d;
            hld_cnt_q   <= hld_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (locked_s) state_d = STABLE;
            STABLE: begin
                if (!locked_s)                  state_d = WAIT_LOCK;
                else if (stb_cnt_q == STB_LAST) state_d = RELEASE;
            end
            RELEASE: begin
                if (!locked_s)                  state_d = WAIT_LOCK;
                else if (hld_cnt_q == HLD_LAST) state_d = RUN;
            end
            RUN: if (!locked_s) state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Counters read zero on the first cycle of their state, so entry clears them.
    always_comb begin
        stb_cnt_d   = (state_q == STABLE)  ? stb_cnt_q + 1'b1 : '0;
        hld_cnt_d   = (state_q == RELEASE) ? hld_cnt_q + 1'b1 : '0;
        loss_evt    = !locked_s && ((state_q == RELEASE) || (state_q == RUN));
        loss_cnt_d  = (loss_evt && (loss_cnt_q != '1)) ? loss_cnt_q + 1'b1 : loss_cnt_q;
        sys_rst_n_d = (state_d == RELEASE) || (state_d == RUN);
        ready_d     = (state_d == RUN);
    end

    assign sys_rst_n     = sys_rst_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed scenarios plus random lock chatter against
// a run-length reference model; a second instance uses a 2-bit loss counter.
module tb_pll_lock_monitor;

    localparam int S = 2;
    localparam int L = 16;
    localparam int H = 8;

    logic       refclk = 1'b0;
    logic       rst    = 1'b0;
    logic       locked = 1'b0;
    logic       sys_rst_n, ready, sys_rst_n2, ready2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [1:0] state, state2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a locked_s delay line, the run length of consecutive
    // high samples seen by the FSM, and the number of losses from an operating state.
    logic [S-1:0] m_pipe;
    int           m_run;
    int           m_losses;

    pll_lock_monitor #(.SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H),
                       .LOSS_CNT_W(8)) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .sys_rst_n(sys_rst_n),
        .ready(ready), .lock_loss_cnt(cnt), .state(state));

    pll_lock_monitor #(.SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H),
                       .LOSS_CNT_W(2)) dut2 (
        .refclk(refclk), .rst(rst), .locked(locked), .sys_rst_n(sys_rst_n2),
        .ready(ready2), .lock_loss_cnt(cnt2), .state(state2));

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe   = '0;
        m_run    = 0;
        m_losses = 0;
    endtask

    function automatic int exp_state();
        if (m_run == 0)      return 0;
        if (m_run <= L)      return 1;
        if (m_run <= L + H)  return 2;
        return 3;
    endfunction

    task automatic model_edge(input logic lk);
        if (m_pipe[S-1]) begin
            if (m_run < 100000) m_run++;
        end else begin
            if (m_run > L) m_losses++;
            m_run = 0;
        end
        m_pipe = {m_pipe[S-2:0], lk};
    endtask

    task automatic compare_all();
        chk("state",   state,      exp_state());
        chk("sysrstn", sys_rst_n,  (m_run > L) ? 1 : 0);
        chk("ready",   ready,      (m_run > L + H) ? 1 : 0);
        chk("cnt8",    cnt,        (m_losses > 255) ? 255 : m_losses);
        chk("cnt2",    cnt2,       (m_losses > 3) ? 3 : m_losses);
    endtask

    task automatic step();
        logic lk;
        lk = locked;
        @(posedge refclk);
        if (rst) model_edge(lk);
        #1;
        compare_all();
    endtask

    // which: 0 = sys_rst_n, 1 = ready, 2 = state==WAIT_LOCK
    task automatic wait_for(input int which, input logic val, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            step();
            n++;
            case (which)
                0:       hit = (sys_rst_n == val);
                1:       hit = (ready == val);
                default: hit = ((state == 2'd0) == val);
            endcase
        end
        if (!hit) chk("wait_timeout", n, -1);
    endtask

    task automatic pulse_reset(input logic lk);
        #2;
        rst = 1'b0;
        model_reset();
        locked = lk;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int n;
        logic rose;
        int exp_sat [5] = '{1, 2, 3, 3, 3};

        model_reset();
        rst = 1'b0;
        locked = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("por_state", state, 0);
        chk("por_rstn", sys_rst_n, 0);
        chk("por_cnt", cnt, 0);
        rst = 1'b1;
        wait_for(0, 1'b1, n);
        chk("acq_sysrstn_edge", n, S + 1 + L);
        begin
            int n2;
            wait_for(1, 1'b1, n2);
            chk("acq_ready_edge", n + n2, S + 1 + L + H);
        end

        // Chatter never qualifies and never counts a loss.
        pulse_reset(1'b0);
        rose = 1'b0;
        for (int i = 0; i < 100; i++) begin
            locked = ((i / 5) % 2 == 0);
            step();
            if (sys_rst_n || cnt != 0) rose = 1'b1;
        end
        chk("chatter_quiet", rose, 0);

        // Loss in RUN and reacquire.
        locked = 1'b1;
        wait_for(1, 1'b1, n);
        locked = 1'b0;
        wait_for(1, 1'b0, n);
        chk("run_loss_edge", n, S + 1);
        chk("run_loss_state", state, 0);
        chk("run_loss_rstn", sys_rst_n, 0);
        chk("run_loss_cnt", cnt, 1);
        for (int i = 0; i < 17; i++) step();
        locked = 1'b1;
        wait_for(1, 1'b1, n);
        chk("reacq_ready_edge", n, S + 1 + L + H);

        // Loss in RELEASE: ready must never rise.
        locked = 1'b0;
        wait_for(2, 1'b1, n);
        locked = 1'b1;
        wait_for(0, 1'b1, n);
        for (int i = 0; i < 4; i++) step();
        locked = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ready) rose = 1'b1;
        end
        chk("rel_no_ready", rose, 0);
        chk("rel_loss_cnt", cnt, 3);
        chk("rel_loss_state", state, 0);

        // Asynchronous reset between edges while in RELEASE.
        locked = 1'b1;
        wait_for(0, 1'b1, n);
        step();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_rstn", sys_rst_n, 0);
        chk("arst_ready", ready, 0);
        chk("arst_state", state, 0);
        chk("arst_cnt", cnt, 0);
        step();
        rst = 1'b1;

        // Saturation of the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            locked = 1'b1;
            wait_for(1, 1'b1, n);
            locked = 1'b0;
            wait_for(2, 1'b1, n);
            chk("sat_cnt2", cnt2, exp_sat[k]);
        end

        // Random lock behaviour with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            if ($urandom_range(0, 29) == 0) pulse_reset($urandom_range(0, 1));
            locked = $urandom_range(0, 1);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
